// File: rtl/seq_controller.sv
// seq_controller: multi-cycle sequencer (IDLE/FETCH/EXEC/MEM/WB/HALT) that
// drives an instruction ROM, latches the instruction for the decoder, and
// handshakes with the data memory. A memory access that never gets
// mem_ready ends in HALT with err set.
// Optional retired-instruction counter: define SEQ_RETIRE_COUNT_EN to build it;
// without the macro, retired is tied to zero.
module seq_controller #(
  parameter int PC_W        = 10,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            start,
  input  logic [8:0]      instr,
  input  logic            dec_branch,
  input  logic            dec_load,
  input  logic            dec_store,
  input  logic            dec_regwrite,
  input  logic            cond_true,
  input  logic [PC_W-1:0] target,
  input  logic            mem_ready,
  output logic [PC_W-1:0] prog_addr,
  output logic [8:0]      ir,
  output logic            mem_req,
  output logic            mem_we,
  output logic            reg_we,
  output logic            done,
  output logic            err,
  output logic [15:0]     retired
);

  localparam logic [8:0] HALT_INSTR = 9'h15F;
  localparam int         WAIT_W     = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_MEM   = 3'd3,
    S_WB    = 3'd4,
    S_HALT  = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [8:0]        ir_q, ir_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic              reg_we_q, reg_we_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              take_target_s;

  // A jump always redirects; a branch redirects only when its condition holds.
  assign take_target_s = (ir_q[8:6] == 3'b111) | (dec_branch & cond_true);

  // Next-state, PC, instruction latch, wait counter and registered-output logic.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    wait_d  = wait_q;
    done_d  = done_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        pc_d = {PC_W{1'b0}};
        if (start) begin
          state_d = S_FETCH;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FETCH: begin
        ir_d    = instr;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        wait_d = {WAIT_W{1'b0}};
        if (ir_q == HALT_INSTR) begin
          state_d = S_HALT;
          done_d  = 1'b1;
        end else if (dec_load | dec_store) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        if (mem_ready) begin
          state_d = S_WB;
          wait_d  = {WAIT_W{1'b0}};
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_HALT;
          err_d   = 1'b1;
          wait_d  = {WAIT_W{1'b0}};
        end else begin
          wait_d  = wait_q + WAIT_W'(1);
        end
      end
      S_WB: begin
        state_d = S_FETCH;
        if (take_target_s) begin
          pc_d = target;
        end else begin
          pc_d = pc_q + PC_W'(1);
        end
      end
      S_HALT: begin
        if (start) begin
          state_d = S_FETCH;
          pc_d    = {PC_W{1'b0}};
          done_d  = 1'b0;
          err_d   = 1'b0;
        end else begin
          state_d = S_HALT;
        end
      end
      default: begin
        state_d = S_IDLE;
        pc_d    = {PC_W{1'b0}};
      end
    endcase
    // Strobes are registered from the upcoming state so they line up with it.
    mem_req_d = (state_d == S_MEM);
    mem_we_d  = (state_d == S_MEM) & dec_store;
    reg_we_d  = (state_d == S_WB) & dec_regwrite;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      pc_q      <= {PC_W{1'b0}};
      ir_q      <= 9'h000;
      wait_q    <= {WAIT_W{1'b0}};
      mem_req_q <= 1'b0;
      mem_we_q  <= 1'b0;
      reg_we_q  <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      wait_q    <= wait_d;
      mem_req_q <= mem_req_d;
      mem_we_q  <= mem_we_d;
      reg_we_q  <= reg_we_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign prog_addr = pc_q;
  assign ir        = ir_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign reg_we    = reg_we_q;
  assign done      = done_q;
  assign err       = err_q;

`ifdef SEQ_RETIRE_COUNT_EN
  logic [15:0] retired_q, retired_d;
  logic        ret_inc_s;
  logic        ret_clr_s;

  assign ret_inc_s = (state_q == S_WB);
  assign ret_clr_s = start & ((state_q == S_IDLE) | (state_q == S_HALT));

  // Saturating retire count: restart clears, each WB exit adds one.
  always_comb begin
    retired_d = retired_q;
    if (ret_clr_s) begin
      retired_d = 16'h0000;
    end else if (ret_inc_s && (retired_q != 16'hFFFF)) begin
      retired_d = retired_q + 16'd1;
    end else begin
      retired_d = retired_q;
    end
  end

  // Retire counter register.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      retired_q <= 16'h0000;
    end else begin
      retired_q <= retired_d;
    end
  end

  assign retired = retired_q;
`else
  assign retired = 16'h0000;
`endif

endmodule

// File: tb/tb_seq_controller.sv
// Directed bench for seq_controller: small ROM and decoder model, fixed
// cycle-by-cycle stimulus with hand-computed expectations.
module tb_seq_controller;

  localparam int PC_W = 10;

  logic            Clk = 1'b0;
  logic            Reset;
  logic            start;
  logic [8:0]      instr;
  logic            dec_branch, dec_load, dec_store, dec_regwrite;
  logic            cond_true;
  logic [PC_W-1:0] target;
  logic            mem_ready;
  logic [PC_W-1:0] prog_addr;
  logic [8:0]      ir;
  logic            mem_req, mem_we, reg_we, done, err;
  logic [15:0]     retired;

  logic [8:0] rom [0:(1<<PC_W)-1];
  int checks   = 0;
  int failures = 0;

`ifdef SEQ_RETIRE_COUNT_EN
  localparam logic [15:0] RET_AFTER_2 = 16'd2;
`else
  localparam logic [15:0] RET_AFTER_2 = 16'd0;
`endif

  // Opcode map: 000 add, 001 load, 010 store, 011 branch, 111 jump; 9'h15F halt.
  localparam logic [8:0] I_ADD   = 9'h001;
  localparam logic [8:0] I_LOAD  = 9'h040;
  localparam logic [8:0] I_STORE = 9'h080;
  localparam logic [8:0] I_BR    = 9'h0C0;
  localparam logic [8:0] I_JMP   = 9'h1C0;
  localparam logic [8:0] I_HALT  = 9'h15F;

  always #5 Clk = ~Clk;

  assign instr        = rom[prog_addr];
  assign dec_load     = (ir[8:6] == 3'b001);
  assign dec_store    = (ir[8:6] == 3'b010);
  assign dec_branch   = (ir[8:6] == 3'b011);
  assign dec_regwrite = (ir[8:6] == 3'b000) || (ir[8:6] == 3'b001);

  seq_controller #(.PC_W(PC_W), .MEM_TIMEOUT(15)) dut (
    .Clk(Clk), .Reset(Reset), .start(start), .instr(instr),
    .dec_branch(dec_branch), .dec_load(dec_load), .dec_store(dec_store),
    .dec_regwrite(dec_regwrite), .cond_true(cond_true), .target(target),
    .mem_ready(mem_ready), .prog_addr(prog_addr), .ir(ir), .mem_req(mem_req),
    .mem_we(mem_we), .reg_we(reg_we), .done(done), .err(err), .retired(retired)
  );

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // From HALT: restart, then advance to the FETCH of the branch at PC 5.
  task automatic run_to_pc5();
    start = 1'b1;
    tick();
    start = 1'b0;
    mem_ready = 1'b1;
    repeat (15) tick();
    mem_ready = 1'b0;
    chk("br_at_pc5", 32'(prog_addr), 32'h005);
    chk("br_ready_ignored", 32'(mem_req), 32'h0);
  endtask

  initial begin
    for (int i = 0; i < (1 << PC_W); i++) rom[i] = I_HALT;
    Reset = 1'b1; start = 1'b0; cond_true = 1'b0; target = 10'h000; mem_ready = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst_pc", 32'(prog_addr), 32'h0);
    chk("rst_ir", 32'(ir), 32'h0);
    chk("rst_outs", 32'({mem_req, mem_we, reg_we, done, err}), 32'h0);
    chk("rst_retired", 32'(retired), 32'h0);

    // Program {add, add, halt}
    rom[0] = I_ADD; rom[1] = I_ADD; rom[2] = I_HALT;
    Reset = 1'b0; start = 1'b1;
    tick();                                   // cycle 1: FETCH
    start = 1'b0;
    chk("p1_c1_reg_we", 32'(reg_we), 32'h0);
    tick();                                   // cycle 2: EXEC
    chk("p1_c2_ir", 32'(ir), 32'(I_ADD));
    tick();                                   // cycle 3: WB
    chk("p1_c3_reg_we", 32'(reg_we), 32'h1);
    tick();                                   // cycle 4: FETCH pc1
    chk("p1_c4_reg_we", 32'(reg_we), 32'h0);
    chk("p1_c4_pc", 32'(prog_addr), 32'h1);
    tick(); tick();                           // cycle 6: WB
    chk("p1_c6_reg_we", 32'(reg_we), 32'h1);
    tick(); tick();                           // cycle 8: EXEC of halt
    chk("p1_c8_ir", 32'(ir), 32'(I_HALT));
    tick();                                   // HALT registered
    chk("p1_done", 32'(done), 32'h1);
    chk("p1_reg_we", 32'(reg_we), 32'h0);
    chk("p1_retired", 32'(retired), 32'(RET_AFTER_2));
    chk("p1_pc_hold", 32'(prog_addr), 32'h2);

    // Load with 3 wait cycles, then store
    rom[0] = I_LOAD; rom[1] = I_STORE; rom[2] = I_HALT;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("ld_done_clr", 32'(done), 32'h0);
    tick();
    chk("ld_exec_req", 32'(mem_req), 32'h0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("ld_mem_req", 32'(mem_req), 32'h1);
      chk("ld_mem_we", 32'(mem_we), 32'h0);
      chk("ld_reg_we", 32'(reg_we), 32'h0);
    end
    mem_ready = 1'b1;
    tick();                                   // WB
    mem_ready = 1'b0;
    chk("ld_wb_req", 32'(mem_req), 32'h0);
    chk("ld_wb_reg_we", 32'(reg_we), 32'h1);
    tick();
    chk("ld_fetch_reg_we", 32'(reg_we), 32'h0);
    chk("ld_next_pc", 32'(prog_addr), 32'h1);
    tick(); tick();                           // MEM for store
    chk("st_mem_req", 32'(mem_req), 32'h1);
    chk("st_mem_we", 32'(mem_we), 32'h1);
    mem_ready = 1'b1;
    tick();                                   // WB
    mem_ready = 1'b0;
    chk("st_wb_reg_we", 32'(reg_we), 32'h0);
    chk("st_wb_mem_we", 32'(mem_we), 32'h0);
    tick(); tick(); tick();
    chk("st_done", 32'(done), 32'h1);
    chk("st_retired", 32'(retired), 32'(RET_AFTER_2));

    // Branch at PC 5, taken then not taken
    for (int i = 0; i < 5; i++) rom[i] = I_ADD;
    rom[5] = I_BR; rom[6] = I_HALT; rom[32] = I_HALT;
    target = 10'h020; cond_true = 1'b1;
    run_to_pc5();
    tick(); tick(); tick();
    chk("br_taken_pc", 32'(prog_addr), 32'h020);
    tick(); tick();
    chk("br_taken_done", 32'(done), 32'h1);
    cond_true = 1'b0;
    run_to_pc5();
    tick(); tick(); tick();
    chk("br_not_taken_pc", 32'(prog_addr), 32'h006);
    tick(); tick();

    // Jump to 3FF ignoring cond_true, wrap to 0, jump again to 010
    rom[0] = I_JMP; rom[10'h3FF] = I_ADD; rom[10'h010] = I_HALT;
    target = 10'h3FF; cond_true = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    chk("jmp_pc_3ff", 32'(prog_addr), 32'h3FF);
    target = 10'h010; cond_true = 1'b1;
    tick(); tick(); tick();
    chk("wrap_pc_0", 32'(prog_addr), 32'h000);
    tick(); tick(); tick();
    chk("jmp_pc_010", 32'(prog_addr), 32'h010);
    tick(); tick();
    chk("jmp_done", 32'(done), 32'h1);

    // Load timeout, start ignored while in MEM
    rom[0] = I_LOAD; cond_true = 1'b0; mem_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();                                   // first MEM cycle
    start = 1'b1;
    repeat (14) tick();                       // MEM cycles 2..15
    start = 1'b0;
    chk("to_req_last", 32'(mem_req), 32'h1);
    chk("to_err_early", 32'(err), 32'h0);
    tick();
    chk("to_err", 32'(err), 32'h1);
    chk("to_done", 32'(done), 32'h0);
    chk("to_req_drop", 32'(mem_req), 32'h0);
    chk("to_retired", 32'(retired), 32'h0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("to_restart_pc", 32'(prog_addr), 32'h0);
    chk("to_err_clr", 32'(err), 32'h0);

    // Reset mid-MEM, with start asserted in the same cycle
    tick(); tick();
    chk("rm_in_mem", 32'(mem_req), 32'h1);
    Reset = 1'b1; start = 1'b1;
    tick();
    Reset = 1'b0; start = 1'b0;
    chk("rm_req", 32'(mem_req), 32'h0);
    chk("rm_pc", 32'(prog_addr), 32'h0);
    chk("rm_ir", 32'(ir), 32'h0);
    chk("rm_retired", 32'(retired), 32'h0);
    chk("rm_flags", 32'({err, done, reg_we}), 32'h0);
    tick(); tick();
    chk("rm_stays_idle", 32'(ir), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
